// File: rtl/pulse_seq_multi.sv
// Multi-channel gated pulse-train sequencer: NCH channels of repeated echoes, SYNC marker and
// receiver inhibit, with config double-buffered so it only changes at a period boundary.
module pulse_seq_multi #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CW       = 32,
    parameter int unsigned RW       = 8,
    parameter int unsigned SYNC_W   = 4,
    parameter int unsigned INH_TAIL = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_period,
    input  logic [NCH*CW-1:0] cfg_delay,
    input  logic [NCH*CW-1:0] cfg_width,
    input  logic [NCH*CW-1:0] cfg_spacing,
    input  logic [NCH*RW-1:0] cfg_repeat,
    output logic              sync_on,
    output logic [NCH-1:0]    pulse_on,
    output logic              inhib,
    output logic              period_done,
    output logic              busy
);

    localparam int unsigned EW = CW + 1;
    localparam int unsigned LW = RW + 1;
    localparam int unsigned TW = $clog2(INH_TAIL + 2);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {CH_WAIT, CH_ON, CH_GAP, CH_DONE} ch_st_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     act_period_q, act_period_d, sh_period_q, sh_period_d;
    logic [NCH*CW-1:0] act_delay_q, act_delay_d, sh_delay_q, sh_delay_d;
    logic [NCH*CW-1:0] act_width_q, act_width_d, sh_width_q, sh_width_d;
    logic [NCH*CW-1:0] act_spacing_q, act_spacing_d, sh_spacing_q, sh_spacing_d;
    logic [NCH*RW-1:0] act_repeat_q, act_repeat_d, sh_repeat_q, sh_repeat_d;
    logic              pend_q, pend_d, ready_q, ready_d;

    ch_st_t            ch_st_q [NCH];
    ch_st_t            ch_st_d [NCH];
    logic [EW-1:0]     rise_q [NCH];
    logic [EW-1:0]     rise_d [NCH];
    logic [EW-1:0]     fall_q [NCH];
    logic [EW-1:0]     fall_d [NCH];
    logic [LW-1:0]     left_q [NCH];
    logic [LW-1:0]     left_d [NCH];

    logic              sync_q, sync_d, inhib_q, inhib_d, done_q, done_d, busy_q, busy_d;
    logic [NCH-1:0]    pulse_q, pulse_d;
    logic [TW-1:0]     tail_q, tail_d;

    logic [CW-1:0]     per_c;
    logic              run_c, last_c, start_c, load_c, take_c;

    // Effective period is clamped to at least 2 ticks.
    always_comb begin
        per_c   = (act_period_q < CW'(2)) ? CW'(2) : act_period_q;
        run_c   = (state_q == S_RUN);
        last_c  = (cnt_q == per_c - CW'(1));
        start_c = run_c && (cnt_q == '0);
        take_c  = cfg_valid && ready_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = S_RUN;
                    load_c  = 1'b1;
                end
            end
            S_RUN: begin
                if (last_c) begin
                    cnt_d  = '0;
                    load_c = 1'b1;
                    if (!enable) state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shadow/active config; a pending shadow promotes only at a period boundary.
    always_comb begin
        act_period_d  = act_period_q;
        act_delay_d   = act_delay_q;
        act_width_d   = act_width_q;
        act_spacing_d = act_spacing_q;
        act_repeat_d  = act_repeat_q;
        sh_period_d   = sh_period_q;
        sh_delay_d    = sh_delay_q;
        sh_width_d    = sh_width_q;
        sh_spacing_d  = sh_spacing_q;
        sh_repeat_d   = sh_repeat_q;
        pend_d        = pend_q;
        if (load_c && pend_q) begin
            act_period_d  = sh_period_q;
            act_delay_d   = sh_delay_q;
            act_width_d   = sh_width_q;
            act_spacing_d = sh_spacing_q;
            act_repeat_d  = sh_repeat_q;
            pend_d        = 1'b0;
        end
        if (take_c) begin
            sh_period_d  = cfg_period;
            sh_delay_d   = cfg_delay;
            sh_width_d   = cfg_width;
            sh_spacing_d = cfg_spacing;
            sh_repeat_d  = cfg_repeat;
            pend_d       = 1'b1;
        end
        ready_d = !pend_d;
    end

    // Per-channel sub-FSM: tracks next rising edge, current falling edge and rises left.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ch_st_t        st;
            logic [EW-1:0] c, per, wid, spc, rise, fall;
            logic [LW-1:0] left;
            logic          hit, on, more;
            c    = EW'(cnt_q);
            per  = EW'(per_c);
            wid  = EW'(act_width_q[k*CW +: CW]);
            spc  = EW'(act_spacing_q[k*CW +: CW]);
            st   = start_c ? CH_WAIT : ch_st_q[k];
            rise = start_c ? EW'(act_delay_q[k*CW +: CW]) : rise_q[k];
            fall = start_c ? '0 : fall_q[k];
            left = start_c ? LW'(act_repeat_q[k*RW +: RW]) + LW'(1) : left_q[k];
            hit  = run_c && (st != CH_DONE) && (left != '0) && (wid != '0) && (c == rise);
            if (hit) begin
                fall = c + wid;
                rise = rise + spc;
                left = left - LW'(1);
            end
            on   = run_c && (wid != '0) && (hit || (c < fall));
            more = (left != '0) && (wid != '0) && (rise < per);
            if (!run_c)     ch_st_d[k] = CH_DONE;
            else if (on)    ch_st_d[k] = CH_ON;
            else if (more)  ch_st_d[k] = (st == CH_WAIT) ? CH_WAIT : CH_GAP;
            else            ch_st_d[k] = CH_DONE;
            rise_d[k]  = rise;
            fall_d[k]  = fall;
            left_d[k]  = left;
            pulse_d[k] = on;
        end
    end

    // Status outputs share the channels' one-tick latency so all edges line up.
    always_comb begin
        sync_d = run_c && (64'(cnt_q) < 64'(SYNC_W));
        done_d = run_c && last_c;
        busy_d = run_c;
        if (!run_c) begin
            inhib_d = 1'b0;
            tail_d  = '0;
        end else if (|pulse_d) begin
            inhib_d = 1'b1;
            tail_d  = TW'(INH_TAIL);
        end else begin
            inhib_d = (tail_q != '0);
            tail_d  = (tail_q != '0) ? tail_q - TW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            act_period_q  <= '0;
            act_delay_q   <= '0;
            act_width_q   <= '0;
            act_spacing_q <= '0;
            act_repeat_q  <= '0;
            sh_period_q   <= '0;
            sh_delay_q    <= '0;
            sh_width_q    <= '0;
            sh_spacing_q  <= '0;
            sh_repeat_q   <= '0;
            pend_q        <= 1'b0;
            ready_q       <= 1'b1;
            for (int k = 0; k < NCH; k++) begin
                ch_st_q[k] <= CH_DONE;
                rise_q[k]  <= '0;
                fall_q[k]  <= '0;
                left_q[k]  <= '0;
            end
            sync_q  <= 1'b0;
            pulse_q <= '0;
            inhib_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            tail_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_period_q  <= act_period_d;
            act_delay_q   <= act_delay_d;
            act_width_q   <= act_width_d;
            act_spacing_q <= act_spacing_d;
            act_repeat_q  <= act_repeat_d;
            sh_period_q   <= sh_period_d;
            sh_delay_q    <= sh_delay_d;
            sh_width_q    <= sh_width_d;
            sh_spacing_q  <= sh_spacing_d;
            sh_repeat_q   <= sh_repeat_d;
            pend_q        <= pend_d;
            ready_q       <= ready_d;
            for (int k = 0; k < NCH; k++) begin
                ch_st_q[k] <= ch_st_d[k];
                rise_q[k]  <= rise_d[k];
                fall_q[k]  <= fall_d[k];
                left_q[k]  <= left_d[k];
            end
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
            inhib_q <= inhib_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            tail_q  <= tail_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign sync_on     = sync_q;
    assign pulse_on    = pulse_q;
    assign inhib       = inhib_q;
    assign period_done = done_q;
    assign busy        = busy_q;

endmodule
